// File: rtl/gauss3x3_window_if.sv
// gauss3x3_window_if: column input and filtered pixel output of the 3x3 Gaussian stage
interface gauss3x3_window_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] row_0;
    logic [DATA_WIDTH-1:0] row_1;
    logic [DATA_WIDTH-1:0] row_2;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  out_valid;
    logic                  out_last;

    modport master (
        output row_0, row_1, row_2, in_valid,
        input  data_out, out_valid, out_last
    );

    modport slave (
        input  row_0, row_1, row_2, in_valid,
        output data_out, out_valid, out_last
    );
endinterface

// File: rtl/gauss3x3_window.sv
// gauss3x3_window: 3x3 window former with rounded [1 2 1]x[1 2 1]/16 smoothing
module gauss3x3_window #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 16,
    parameter int LENGTH     = 100
) (
    input logic              clk,
    input logic              rst_n,
    gauss3x3_window_if.slave io
);
    localparam int HW = DATA_WIDTH + 2;
    localparam int SW = DATA_WIDTH + 4;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LENGTH - 1);

    logic [DATA_WIDTH-1:0] w_q [3][3];
    logic [DATA_WIDTH-1:0] w_d [3][3];
    logic [ADDR_WIDTH-1:0] col_q, col_d;
    logic                  wv_q, wv_d;
    logic                  wl_q, wl_d;
    logic [HW-1:0]         h_q [3];
    logic [HW-1:0]         h_d [3];
    logic                  v1_q, v1_d;
    logic                  last1_q, last1_d;
    logic [SW-1:0]         s;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  ov_q, ov_d;
    logic                  ol_q, ol_d;

    // Window shift and column tracking; valid/last tags travel with the freshly formed window
    always_comb begin
        w_d   = w_q;
        col_d = col_q;
        wv_d  = 1'b0;
        wl_d  = 1'b0;
        if (io.in_valid) begin
            for (int r = 0; r < 3; r++) begin
                w_d[r][0] = w_q[r][1];
                w_d[r][1] = w_q[r][2];
            end
            w_d[0][2] = io.row_0;
            w_d[1][2] = io.row_1;
            w_d[2][2] = io.row_2;
            col_d     = (col_q == LAST) ? '0 : col_q + 1'b1;
            wv_d      = (col_q >= ADDR_WIDTH'(2));
            wl_d      = (col_q == LAST);
        end
    end

    // Stage 1: horizontal [1 2 1] per row
    always_comb begin
        for (int r = 0; r < 3; r++)
            h_d[r] = HW'(w_q[r][0]) + (HW'(w_q[r][1]) << 1) + HW'(w_q[r][2]);
        v1_d    = wv_q;
        last1_d = wl_q;
    end

    // Stage 2: vertical [1 2 1] and round-half-up divide by 16; output holds between pixels
    always_comb begin
        s      = SW'(h_q[0]) + (SW'(h_q[1]) << 1) + SW'(h_q[2]);
        dout_d = v1_q ? DATA_WIDTH'((s + SW'(8)) >> 4) : dout_q;
        ov_d   = v1_q;
        ol_d   = last1_q;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_q     <= '{default: '0};
            col_q   <= '0;
            wv_q    <= 1'b0;
            wl_q    <= 1'b0;
            h_q     <= '{default: '0};
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            dout_q  <= '0;
            ov_q    <= 1'b0;
            ol_q    <= 1'b0;
        end else begin
            w_q     <= w_d;
            col_q   <= col_d;
            wv_q    <= wv_d;
            wl_q    <= wl_d;
            h_q     <= h_d;
            v1_q    <= v1_d;
            last1_q <= last1_d;
            dout_q  <= dout_d;
            ov_q    <= ov_d;
            ol_q    <= ol_d;
        end
    end

    assign io.data_out  = dout_q;
    assign io.out_valid = ov_q;
    assign io.out_last  = ol_q;
endmodule

// File: tb/tb_gauss3x3_window.sv
// tb_gauss3x3_window: directed and random columns checked against a 2-D convolution model
module tb_gauss3x3_window;
    localparam int DW  = 16;
    localparam int AW  = 3;
    localparam int LEN = 8;

    typedef struct {
        int due;
        int val;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gauss3x3_window_if #(.DATA_WIDTH(DW)) io();

    gauss3x3_window #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LENGTH(LEN)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (io)
    );

    exp_t            q[$];
    int              hist[3][LEN];
    int              kw[3] = '{1, 2, 1};
    int              col = 0;
    int              cycle = 0;
    int              passed = 0;
    int              total = 0;
    logic [DW-1:0]   exp_dout = '0;
    logic            exp_last = 1'b0;

    // Model: a full 3x3 convolution over the stored columns of the current row
    task automatic accept(input int a, input int b, input int c);
        exp_t e;
        int   s;
        hist[0][col] = a;
        hist[1][col] = b;
        hist[2][col] = c;
        if (col >= 2) begin
            s = 0;
            for (int rr = 0; rr < 3; rr++)
                for (int cc = 0; cc < 3; cc++)
                    s += kw[rr] * kw[cc] * hist[rr][col - 2 + cc];
            e.due  = cycle + 2;
            e.val  = (s + 8) / 16;
            e.last = (col == LEN - 1);
            q.push_back(e);
        end
        col = (col + 1) % LEN;
    endtask

    task automatic check();
        bit ev;
        ev = 1'b0;
        if (q.size() > 0)
            ev = (q[0].due == cycle);
        total++;
        assert (io.out_valid === ev) passed++;
        else $error("FAIL out_valid cyc=%0d got %b exp %b", cycle, io.out_valid, ev);
        if (ev) begin
            exp_dout = DW'(q[0].val);
            exp_last = q[0].last;
            void'(q.pop_front());
        end else begin
            exp_last = 1'b0;
        end
        total++;
        assert (io.data_out === exp_dout) passed++;
        else $error("FAIL data_out cyc=%0d got %0d exp %0d", cycle, io.data_out, exp_dout);
        total++;
        assert (io.out_last === exp_last) passed++;
        else $error("FAIL out_last cyc=%0d got %b exp %b", cycle, io.out_last, exp_last);
    endtask

    task automatic beat(input bit v, input int a, input int b, input int c);
        io.in_valid = v;
        io.row_0    = DW'(a);
        io.row_1    = DW'(b);
        io.row_2    = DW'(c);
        @(posedge clk);
        cycle++;
        if (!rst_n) begin
            q.delete();
            col      = 0;
            exp_dout = '0;
        end else if (v) begin
            accept(a, b, c);
        end
        @(negedge clk);
        check();
    endtask

    initial begin
        int n;
        bit v;
        io.in_valid = 1'b0;
        io.row_0    = '0;
        io.row_1    = '0;
        io.row_2    = '0;
        rst_n = 1'b0;
        beat(1, 7, 7, 7);
        beat(1, 7, 7, 7);
        rst_n = 1'b1;
        // flat field, three full rows
        for (int i = 0; i < 3 * LEN; i++) beat(1, 100, 100, 100);
        // impulse of 16 in the middle row at col 3
        for (int i = 0; i < LEN; i++) beat(1, 0, (i == 3) ? 16 : 0, 0);
        // lone 1 in the centre rounds away
        for (int i = 0; i < LEN; i++) beat(1, 0, (i == 3) ? 1 : 0, 0);
        // full-scale input
        for (int i = 0; i < 2 * LEN; i++) beat(1, 65535, 65535, 65535);
        // gapped flat field
        for (int i = 0; i < 2 * LEN; i++) begin
            beat(1, 50, 50, 50);
            beat(0, 0, 0, 0);
        end
        // reset after col 5, valid held high during reset
        for (int i = 0; i < 6; i++) beat(1, 30 * i, 40, 90);
        rst_n = 1'b0;
        beat(1, 999, 999, 999);
        rst_n = 1'b1;
        for (int i = 0; i < LEN; i++) beat(1, 10 + i, 20, 30 * i);
        // stale-window suppression
        for (int i = 0; i < LEN; i++) beat(1, 200, 200, 200);
        for (int i = 0; i < LEN; i++) beat(1, 0, 0, 0);
        // random data with random gaps
        n = 0;
        while (n < 4 * LEN) begin
            v = ($urandom_range(0, 3) != 0);
            beat(v, $urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535));
            if (v) n++;
        end
        for (int i = 0; i < 4; i++) beat(0, 0, 0, 0);
        total++;
        assert (q.size() == 0) passed++;
        else $error("FAIL drain got %0d pending exp 0", q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
